// File: rtl/hazard_control_pkg.sv
// -----------------------------------------------------------------------------
// hazard_control_pkg
// Shared processor constants: instruction field positions, opcode and ALU-op
// encodings, architectural register numbers and the multdiv sequencer state
// encoding. Imported by the hazard controller and the source decoder.
// -----------------------------------------------------------------------------
package hazard_control_pkg;

   // Instruction field positions
   localparam int unsigned OPCODE_MSB = 31;
   localparam int unsigned OPCODE_LSB = 27;
   localparam int unsigned RD_MSB     = 26;
   localparam int unsigned RD_LSB     = 22;
   localparam int unsigned RS_MSB     = 21;
   localparam int unsigned RS_LSB     = 17;
   localparam int unsigned RT_MSB     = 16;
   localparam int unsigned RT_LSB     = 12;
   localparam int unsigned ALU_MSB    = 6;
   localparam int unsigned ALU_LSB    = 2;

   // Opcodes
   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_J     = 5'b00001;
   localparam logic [4:0] OP_BNE   = 5'b00010;
   localparam logic [4:0] OP_JAL   = 5'b00011;
   localparam logic [4:0] OP_JR    = 5'b00100;
   localparam logic [4:0] OP_ADDI  = 5'b00101;
   localparam logic [4:0] OP_BLT   = 5'b00110;
   localparam logic [4:0] OP_SW    = 5'b00111;
   localparam logic [4:0] OP_LW    = 5'b01000;
   localparam logic [4:0] OP_SETX  = 5'b10101;
   localparam logic [4:0] OP_BEX   = 5'b10110;

   // R-type ALU ops handled by the multdiv unit
   localparam logic [4:0] ALU_MULT = 5'b00110;
   localparam logic [4:0] ALU_DIV  = 5'b00111;

   // Architectural registers with special meaning
   localparam logic [4:0] R0  = 5'd0;
   localparam logic [4:0] R30 = 5'd30;  // rstatus
   localparam logic [4:0] R31 = 5'd31;  // link register

   // Multdiv sequencer states
   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StWait = 2'b01,
      StDone = 2'b10
   } md_state_e;

   // True for an R-type mult or div.
   function automatic logic is_multdiv(input logic [4:0] opcode, input logic [4:0] alu_op);
      return (opcode == OP_RTYPE) && ((alu_op == ALU_MULT) || (alu_op == ALU_DIV));
   endfunction

endpackage

// File: rtl/hazard_control_insn_sources.sv
// -----------------------------------------------------------------------------
// insn_sources
// Decodes an instruction into the register numbers it reads, each with a
// use-valid bit. Shared with the forwarding logic.
//   insn        in   32  instruction word
//   src_a       out  5   first source (always rs)
//   src_a_used  out  1   src_a is actually read
//   src_b       out  5   second source (rt for R-type, rd otherwise)
//   src_b_used  out  1   src_b is actually read
// -----------------------------------------------------------------------------
module insn_sources
   import hazard_control_pkg::*;
(
   input  logic [31:0] insn,
   output logic [4:0]  src_a,
   output logic        src_a_used,
   output logic [4:0]  src_b,
   output logic        src_b_used
);

   logic [4:0] opcode;
   logic [4:0] rd;
   logic [4:0] rs;
   logic [4:0] rt;
   logic       unused_insn;

   assign opcode = insn[OPCODE_MSB:OPCODE_LSB];
   assign rd     = insn[RD_MSB:RD_LSB];
   assign rs     = insn[RS_MSB:RS_LSB];
   assign rt     = insn[RT_MSB:RT_LSB];

   // Immediate / shamt / ALU-op bits never name a register.
   assign unused_insn = ^insn[11:0];

   always_comb begin
      src_a      = rs;
      src_a_used = 1'b0;
      src_b      = rd;
      src_b_used = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            src_a_used = 1'b1;
            src_b      = rt;
            src_b_used = 1'b1;
         end
         OP_ADDI, OP_LW: begin
            src_a_used = 1'b1;
         end
         // Stores read rd as data; branches compare rd against rs.
         OP_SW, OP_BNE, OP_BLT: begin
            src_a_used = 1'b1;
            src_b_used = 1'b1;
         end
         OP_JR: begin
            src_b_used = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/hazard_control.sv
// -----------------------------------------------------------------------------
// hazard_control
// Interlock and flush controller for the five-stage pipeline. Handles the
// hazards operand forwarding cannot: load-use stalls, taken-branch flushes and
// sequencing of the multi-cycle multiply/divide unit.
//   clock, reset        pipeline clock; asynchronous active-high reset
//   fd_insn, dx_insn    instructions in the FD and DX latches
//   branch_taken        execute resolved a taken branch/jump this cycle
//   md_ready            multdiv result valid
//   md_exception        multdiv error, qualified by md_ready
//   stall_pc/fd/dx      hold the PC / FD / DX latches
//   nop_dx, nop_xm      load a bubble into DX / XM
//   flush_fd            load a bubble into FD
//   ctrl_mult/ctrl_div  one-cycle start pulses to multdiv
//   md_done             XM captures the multdiv result this cycle
//   md_error            XM writes rstatus instead (exception or timeout)
//   stall_count         saturating count of cycles with stall_pc high
// -----------------------------------------------------------------------------
module hazard_control
   import hazard_control_pkg::*;
#(
   parameter int unsigned MD_TIMEOUT = 40,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [31:0]      fd_insn,
   input  logic [31:0]      dx_insn,
   input  logic             branch_taken,
   input  logic             md_ready,
   input  logic             md_exception,
   output logic             stall_pc,
   output logic             stall_fd,
   output logic             stall_dx,
   output logic             nop_dx,
   output logic             nop_xm,
   output logic             flush_fd,
   output logic             ctrl_mult,
   output logic             ctrl_div,
   output logic             md_done,
   output logic             md_error,
   output logic [CNT_W-1:0] stall_count
);

   localparam int unsigned TMO_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MD_TIMEOUT - 1);

   // ---------------------------------------------------------------------------
   // Decode
   // ---------------------------------------------------------------------------
   logic [4:0] dx_opcode;
   logic [4:0] dx_rd;
   logic [4:0] dx_alu;
   logic       dx_is_md;
   logic       unused_dx;

   assign dx_opcode = dx_insn[OPCODE_MSB:OPCODE_LSB];
   assign dx_rd     = dx_insn[RD_MSB:RD_LSB];
   assign dx_alu    = dx_insn[ALU_MSB:ALU_LSB];
   assign dx_is_md  = is_multdiv(dx_opcode, dx_alu);
   assign unused_dx = ^{dx_insn[RS_MSB:7], dx_insn[1:0]};

   logic [4:0] fd_src_a;
   logic       fd_src_a_used;
   logic [4:0] fd_src_b;
   logic       fd_src_b_used;

   insn_sources u_fd_sources (
      .insn       (fd_insn),
      .src_a      (fd_src_a),
      .src_a_used (fd_src_a_used),
      .src_b      (fd_src_b),
      .src_b_used (fd_src_b_used)
   );

   // A load into r0 never produces a value, so it cannot create a hazard.
   logic load_use;

   assign load_use = (dx_opcode == OP_LW) && (dx_rd != R0) &&
                     ((fd_src_a_used && (fd_src_a == dx_rd)) ||
                      (fd_src_b_used && (fd_src_b == dx_rd)));

   // ---------------------------------------------------------------------------
   // Multdiv sequencer
   // ---------------------------------------------------------------------------
   md_state_e        state_q, state_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             err_q, err_d;
   logic             md_hold;  // start cycle or waiting: freeze front end, bubble XM

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         tmo_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      tmo_d     = tmo_q;
      err_d     = err_q;
      md_hold   = 1'b0;
      ctrl_mult = 1'b0;
      ctrl_div  = 1'b0;
      md_done   = 1'b0;
      md_error  = 1'b0;
      unique case (state_q)
         StIdle: begin
            // md_ready here belongs to nobody and is dropped.
            if (dx_is_md) begin
               md_hold   = 1'b1;
               ctrl_mult = (dx_alu == ALU_MULT);
               ctrl_div  = (dx_alu == ALU_DIV);
               tmo_d     = '0;
               err_d     = 1'b0;
               state_d   = StWait;
            end
         end
         StWait: begin
            md_hold = 1'b1;
            // A result arriving on the last allowed cycle still wins.
            if (md_ready) begin
               err_d   = md_exception;
               state_d = StDone;
            end else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = StDone;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         StDone: begin
            md_done  = 1'b1;
            md_error = err_q;
            state_d  = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Pipeline latch controls: multdiv > branch flush > load-use
   // ---------------------------------------------------------------------------
   always_comb begin
      stall_pc = 1'b0;
      stall_fd = 1'b0;
      stall_dx = 1'b0;
      nop_dx   = 1'b0;
      nop_xm   = 1'b0;
      flush_fd = 1'b0;
      if (md_hold) begin
         stall_pc = 1'b1;
         stall_fd = 1'b1;
         stall_dx = 1'b1;
         nop_xm   = 1'b1;
      end else if (branch_taken) begin
         // The instruction behind the branch is discarded, so its hazard is moot.
         flush_fd = 1'b1;
         nop_dx   = 1'b1;
      end else if (load_use) begin
         stall_pc = 1'b1;
         stall_fd = 1'b1;
         nop_dx   = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Stall performance counter
   // ---------------------------------------------------------------------------
   logic [CNT_W-1:0] stall_count_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stall_count_q <= '0;
      end else if (stall_pc && (stall_count_q != {CNT_W{1'b1}})) begin
         stall_count_q <= stall_count_q + 1'b1;
      end
   end

   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_control.sv
module tb_hazard_control;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] fd_insn = '0;
   logic [31:0] dx_insn = '0;
   logic        branch_taken = 1'b0;
   logic        md_ready = 1'b0;
   logic        md_exception = 1'b0;

   logic        stall_pc, stall_fd, stall_dx, nop_dx, nop_xm, flush_fd;
   logic        ctrl_mult, ctrl_div, md_done, md_error;
   logic [15:0] stall_count;

   // Narrow-counter instance used only to observe saturation.
   logic        s_stall_pc, s_stall_fd, s_stall_dx, s_nop_dx, s_nop_xm, s_flush_fd;
   logic        s_ctrl_mult, s_ctrl_div, s_md_done, s_md_error;
   logic [2:0]  sat_count;

   localparam logic [31:0] NOP = 32'd0;

   always #5 clock = ~clock;

   hazard_control #(.MD_TIMEOUT(40), .CNT_W(16)) dut (
      .clock(clock), .reset(reset), .fd_insn(fd_insn), .dx_insn(dx_insn),
      .branch_taken(branch_taken), .md_ready(md_ready), .md_exception(md_exception),
      .stall_pc(stall_pc), .stall_fd(stall_fd), .stall_dx(stall_dx), .nop_dx(nop_dx),
      .nop_xm(nop_xm), .flush_fd(flush_fd), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
      .md_done(md_done), .md_error(md_error), .stall_count(stall_count)
   );

   hazard_control #(.MD_TIMEOUT(4), .CNT_W(3)) dut_sat (
      .clock(clock), .reset(reset), .fd_insn(fd_insn), .dx_insn(dx_insn),
      .branch_taken(branch_taken), .md_ready(md_ready), .md_exception(md_exception),
      .stall_pc(s_stall_pc), .stall_fd(s_stall_fd), .stall_dx(s_stall_dx),
      .nop_dx(s_nop_dx), .nop_xm(s_nop_xm), .flush_fd(s_flush_fd),
      .ctrl_mult(s_ctrl_mult), .ctrl_div(s_ctrl_div), .md_done(s_md_done),
      .md_error(s_md_error), .stall_count(sat_count)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Instruction encoders
   function automatic logic [31:0] enc_r(input logic [4:0] alu, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic [4:0] rt);
      return {5'd0, rd, rs, rt, 5'd0, alu, 2'b00};
   endfunction

   function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic [16:0] imm);
      return {op, rd, rs, imm};
   endfunction

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   function automatic bit reads_reg(input logic [31:0] fd, input logic [4:0] r);
      logic [4:0] op;
      op = fd[31:27];
      case (op)
         5'd0:             return (fd[21:17] == r) || (fd[16:12] == r);
         5'd5, 5'd8:       return (fd[21:17] == r);
         5'd7, 5'd2, 5'd6: return (fd[21:17] == r) || (fd[26:22] == r);
         5'd4:             return (fd[26:22] == r);
         default:          return 1'b0;
      endcase
   endfunction

   function automatic bit lu_hazard(input logic [31:0] dx, input logic [31:0] fd);
      return (dx[31:27] == 5'd8) && (dx[26:22] != 5'd0) && reads_reg(fd, dx[26:22]);
   endfunction

   function automatic bit is_md(input logic [31:0] dx);
      return (dx[31:27] == 5'd0) && ((dx[6:2] == 5'd6) || (dx[6:2] == 5'd7));
   endfunction

   localparam int P_IDLE = 0;
   localparam int P_WAIT = 1;
   localparam int P_DONE = 2;

   int m_phase  = P_IDLE;
   int m_waited = 0;
   int m_count  = 0;
   bit m_err    = 1'b0;

   int n_mult  = 0;
   int n_done  = 0;
   int n_stall = 0;

   always @(negedge clock) begin
      bit start, hold, br, lu, exp_stall;
      logic [9:0] exp_v, act_v;
      if (reset) begin
         m_phase  = P_IDLE;
         m_waited = 0;
         m_count  = 0;
         m_err    = 1'b0;
      end
      start     = (m_phase == P_IDLE) && is_md(dx_insn);
      hold      = start || (m_phase == P_WAIT);
      br        = branch_taken;
      lu        = lu_hazard(dx_insn, fd_insn);
      exp_stall = hold || (!br && lu);
      exp_v = {exp_stall, exp_stall, hold, !hold && (br || lu), hold, !hold && br,
               start && (dx_insn[6:2] == 5'd6), start && (dx_insn[6:2] == 5'd7),
               m_phase == P_DONE, (m_phase == P_DONE) && m_err};
      act_v = {stall_pc, stall_fd, stall_dx, nop_dx, nop_xm, flush_fd,
               ctrl_mult, ctrl_div, md_done, md_error};
      check("outputs", 32'(act_v), 32'(exp_v));
      check("stall_count", 32'(stall_count), 32'(m_count));
      if (!reset) begin
         n_mult  += int'(ctrl_mult);
         n_done  += int'(md_done);
         n_stall += int'(stall_pc);
         if (exp_stall && m_count < 65535) m_count++;
         if (start) begin
            m_phase  = P_WAIT;
            m_waited = 0;
         end else if (m_phase == P_WAIT) begin
            m_waited++;
            if (md_ready) begin
               m_phase = P_DONE;
               m_err   = md_exception;
            end else if (m_waited == 40) begin
               m_phase = P_DONE;
               m_err   = 1'b1;
            end
         end else if (m_phase == P_DONE) begin
            m_phase = P_IDLE;
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // Directed scenarios
   // ---------------------------------------------------------------------------
   initial begin
      tick();
      tick();
      #1;
      check("reset_count", 32'(stall_count), 32'd0);
      check("reset_md_error", 32'(md_error), 32'd0);
      check("reset_stall_pc", 32'(stall_pc), 32'd0);
      reset = 1'b0;
      tick();

      // Load-use on add: one stall cycle
      dx_insn = enc_i(5'd8, 5'd5, 5'd1, 17'd0);
      fd_insn = enc_r(5'd0, 5'd6, 5'd5, 5'd2);
      #1;
      check("lu_stall_pc", 32'(stall_pc), 32'd1);
      check("lu_nop_dx", 32'(nop_dx), 32'd1);
      tick();
      dx_insn = NOP;
      #1;
      check("lu_released", 32'(stall_pc), 32'd0);
      check("lu_count", 32'(stall_count), 32'd1);

      // lw into r0: no hazard
      dx_insn = enc_i(5'd8, 5'd0, 5'd1, 17'd0);
      fd_insn = enc_r(5'd0, 5'd6, 5'd0, 5'd2);
      #1;
      check("lu_r0", 32'(stall_pc), 32'd0);
      tick();

      // sw store data reads rd
      dx_insn = enc_i(5'd8, 5'd7, 5'd2, 17'd0);
      fd_insn = enc_i(5'd7, 5'd7, 5'd1, 17'd4);
      #1;
      check("sw_rd_stall", 32'(stall_pc), 32'd1);
      tick();

      // addi with r3 bits in the rt position is not a read of r3
      dx_insn = enc_i(5'd8, 5'd3, 5'd2, 17'd0);
      fd_insn = enc_i(5'd5, 5'd9, 5'd1, 17'h03000);
      #1;
      check("addi_rt_ignored", 32'(stall_pc), 32'd0);
      tick();

      // Branch over a load-use hazard
      dx_insn = enc_i(5'd8, 5'd5, 5'd1, 17'd0);
      fd_insn = enc_r(5'd0, 5'd6, 5'd5, 5'd2);
      branch_taken = 1'b1;
      #1;
      check("br_flush_fd", 32'(flush_fd), 32'd1);
      check("br_nop_dx", 32'(nop_dx), 32'd1);
      check("br_no_stall", 32'(stall_pc), 32'd0);
      tick();
      branch_taken = 1'b0;
      dx_insn = NOP;
      fd_insn = NOP;
      #1;
      check("br_count", 32'(stall_count), 32'd2);

      // md_ready while idle is ignored (model checks md_done stays low)
      md_ready = 1'b1;
      tick();
      md_ready = 1'b0;

      // mult with ready 17 cycles after the start pulse, from a fresh reset
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_mult = 0;
      n_done = 0;
      n_stall = 0;
      dx_insn = enc_r(5'd6, 5'd3, 5'd1, 5'd2);
      for (int k = 0; k < 18; k++) begin
         md_ready = (k == 17);
         tick();
      end
      md_ready = 1'b0;
      #1;
      check("mult_done", 32'(md_done), 32'd1);
      check("mult_err", 32'(md_error), 32'd0);
      check("mult_done_stall", 32'(stall_pc), 32'd0);
      tick();
      dx_insn = NOP;
      #1;
      check("mult_count", 32'(stall_count), 32'd18);
      check("mult_pulses", 32'(n_mult), 32'd1);
      check("mult_stall_cycles", 32'(n_stall), 32'd18);
      check("mult_done_cycles", 32'(n_done), 32'd1);
      check("sat_count", 32'(sat_count), 32'd7);

      // div by zero
      dx_insn = enc_r(5'd7, 5'd3, 5'd1, 5'd0);
      for (int k = 0; k < 3; k++) begin
         md_ready = (k == 2);
         md_exception = (k == 2);
         tick();
      end
      md_ready = 1'b0;
      md_exception = 1'b0;
      #1;
      check("div0_done", 32'(md_done), 32'd1);
      check("div0_err", 32'(md_error), 32'd1);
      tick();
      dx_insn = NOP;

      // Timeout: start plus 40 WAIT cycles, then DONE with error
      n_stall = 0;
      dx_insn = enc_r(5'd7, 5'd3, 5'd1, 5'd0);
      for (int k = 0; k < 41; k++) tick();
      #1;
      check("tmo_done", 32'(md_done), 32'd1);
      check("tmo_err", 32'(md_error), 32'd1);
      check("tmo_stall_cycles", 32'(n_stall), 32'd41);
      tick();
      dx_insn = NOP;

      // Ready on the final allowed WAIT cycle counts as ready
      dx_insn = enc_r(5'd6, 5'd3, 5'd1, 5'd2);
      for (int k = 0; k < 41; k++) begin
         md_ready = (k == 40);
         tick();
      end
      md_ready = 1'b0;
      #1;
      check("edge_done", 32'(md_done), 32'd1);
      check("edge_err", 32'(md_error), 32'd0);
      tick();
      dx_insn = NOP;

      // Reset during the 5th WAIT cycle
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_done = 0;
      dx_insn = enc_r(5'd6, 5'd3, 5'd1, 5'd2);
      for (int k = 0; k < 5; k++) tick();
      #1;
      check("rst_wait_stalling", 32'(stall_pc), 32'd1);
      reset = 1'b1;
      dx_insn = NOP;
      #1;
      check("rst_stall_pc", 32'(stall_pc), 32'd0);
      check("rst_stall_dx", 32'(stall_dx), 32'd0);
      check("rst_nop_xm", 32'(nop_xm), 32'd0);
      tick();
      reset = 1'b0;
      tick();
      tick();
      check("rst_count", 32'(stall_count), 32'd0);
      check("rst_no_done", 32'(n_done), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/hazard_control.md
# hazard_control

Interlock and flush controller for the five-stage pipeline. It is the counterpart to operand forwarding: it handles the hazards that forwarding cannot resolve. It freezes PC/FD, injects bubbles into DX or XM, and sequences the multi-cycle multiply/divide unit. It sits beside the decode and execute stages and drives the latch enables and NOP selects of the pipeline registers.

## Interface
Parameters:
- MD_TIMEOUT, 40, maximum cycles to wait for `md_ready` before forcing release.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clock  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- fd_insn  in  32  instruction in the FD latch.
- dx_insn  in  32  instruction in the DX latch.
- branch_taken  in  1  execute stage resolved a taken branch or jump this cycle.
- md_ready  in  1  multdiv result valid.
- md_exception  in  1  multdiv error (divide by zero, overflow); sampled with `md_ready`.
- stall_pc  out  1  hold the PC.
- stall_fd  out  1  hold the FD latch.
- stall_dx  out  1  hold the DX latch.
- nop_dx  out  1  load a NOP into DX.
- nop_xm  out  1  load a NOP into XM.
- flush_fd  out  1  load a NOP into FD.
- ctrl_mult, ctrl_div  out  1  one-cycle start pulses to multdiv.
- md_done  out  1  release cycle: XM captures the multdiv result.
- md_error  out  1  `md_exception` or timeout on release; XM writes rstatus (r30).
- stall_count  out  CNT_W  saturating count of stalled cycles.

## Operation
- Fields: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], ALU op [6:2].
- Multdiv instruction: opcode 00000 with ALU op 00110 (mult) or 00111 (div).
- Load-use hazard, all of:
  - dx opcode is 01000 (lw);
  - dx rd is not r0;
  - dx rd equals a source of fd_insn. R-type sources are rs and rt. addi/lw/sw/bne/blt source rs. sw/bne/blt/jr also source rd.
  - Response: stall_pc=stall_fd=1, nop_dx=1.
- Branch: `branch_taken` gives flush_fd=1 and nop_dx=1. The load-use stall is suppressed that cycle.
- FSM states:
  - IDLE. If dx holds a multdiv instruction: pulse ctrl_mult or ctrl_div, then go to WAIT.
  - WAIT. Stall. On `md_ready`, go to DONE. If `md_ready` is not seen within MD_TIMEOUT cycles, go to DONE with `md_error` set.
  - DONE. Exactly one cycle; returns to IDLE.
- In the IDLE start cycle and in all WAIT cycles:
  - stall_pc = stall_fd = stall_dx = 1;
  - nop_xm = 1;
  - branch and load-use responses are masked.
- DONE: md_done=1, all stalls 0, so DX advances. md_error = latched (md_exception OR timeout).
- Priority: multdiv sequencing > branch flush > load-use.
- stall_count increments on every cycle in which stall_pc=1, and saturates at all-ones.

## Timing
- All stall, NOP and flush outputs are combinational from the inputs and current state. They take effect at the next clock edge.
- Start pulse and FSM:
  - ctrl_mult/ctrl_div is high only in the IDLE cycle that detects the multdiv instruction.
  - WAIT is entered on the following edge.
  - If `md_ready` arrives in the first WAIT cycle, DONE follows on the next edge. Minimum occupancy is 3 cycles: start, WAIT, DONE.
- Timeout counter: cleared on entering WAIT, incremented in each WAIT cycle. When the count reaches MD_TIMEOUT-1 without `md_ready`, the FSM moves to DONE.
- `md_ready` and timeout in the same cycle: treated as ready; md_error = md_exception.
- `md_ready` while in IDLE: ignored.
- Reset values: FSM IDLE, timeout counter 0, stall_count 0, md_error 0. Every registered output is 0. Combinational outputs follow the inputs.
- Reset mid-WAIT: the FSM returns to IDLE immediately. No md_done is issued.

## Structure
- Shared package (the existing processor constants package):
  - opcode and ALU-op constants;
  - register constants R0, R30, R31;
  - FSM state encoding.
- One sub-module, `insn_sources`: decodes an instruction into its source register numbers plus use-valid bits. It is reusable by the forwarding logic.

## Test plan
- Load-use: dx=lw r5, fd=add r6,r5,r2 → stall_pc=stall_fd=nop_dx=1 for exactly one cycle. Repeat with dx=lw r0 → no stall.
- sw store data: dx=lw r7, fd=sw r7,4(r1) → stall asserted, because rd is a source.
- Branch over hazard: branch_taken=1 while a load-use condition exists → flush_fd=nop_dx=1, stall_pc=0, stall_count unchanged.
- mult: dx=mult, `md_ready` 17 cycles after the start pulse → ctrl_mult pulses once, stalls held 18 cycles, then one md_done cycle, md_error=0, stall_count=18.
- div by zero: `md_ready` with md_exception=1 → md_done=md_error=1 in the DONE cycle. Separately, no `md_ready` → DONE on the timeout with md_error=1 after 40 WAIT cycles.
- Reset asserted in the 5th WAIT cycle → all stalls drop immediately, FSM IDLE, no md_done; stall_count is 0 after release.
